// File: rtl/tiny_lsu.sv
// Single-request load/store unit for tiny_cpu with a private byte-laned data RAM.
// Optional MMIO LED register at 0x1000 enabled by TINY_LSU_MMIO_LED_EN.
module tiny_lsu #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [2:0]        led_out
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

   state_t      state_reg;
   logic        ready_reg;
   logic        rsp_valid_reg;
   logic        rsp_err_reg;
   logic [31:0] rsp_rdata_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  lane_reg;
   logic        mmio_reg;

   logic             accept;
   logic             legal;
   logic             aligned;
   logic             req_ok;
   logic             is_mmio;
   logic             ram_we;
   logic             ram_re;
   logic [IDX_W-1:0] idx;
   logic [3:0]       wr_be;
   logic [31:0]      wr_data;
   logic [31:0]      rd_word;
   logic [31:0]      ld_word;
   logic [31:0]      ld_ext;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [2:0]       led_val;
   logic             unused_addr;

   assign accept      = req_valid && ready_reg;
   assign idx         = req_addr[IDX_W+1:2];
   assign unused_addr = ^req_addr;

`ifdef TINY_LSU_MMIO_LED_EN
   logic [2:0] led_reg;

   assign is_mmio = (req_addr == ADDR_W'(32'h0000_1000));
   assign led_val = led_reg;

   always_ff @(posedge CLK) begin
      if (RST)
         led_reg <= 3'b000;
      else if (accept && req_we && req_ok && is_mmio)
         led_reg <= req_wdata[2:0];
   end
`else
   assign is_mmio = 1'b0;
   assign led_val = 3'b000;
`endif

   always_comb begin
      legal = 1'b0;
      if (req_we)
         legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else
         legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
   end

   always_comb begin
      aligned = 1'b1;
      case (req_funct3[1:0])
         2'b01:   aligned = !req_addr[0];
         2'b10:   aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   assign req_ok = legal && aligned;
   // A reset coinciding with an accept edge must not leave a half-accepted write behind.
   assign ram_we = accept && req_we && req_ok && !is_mmio && !RST;
   assign ram_re = accept && !req_we && req_ok && !is_mmio;

   always_comb begin
      wr_be   = 4'b0000;
      wr_data = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            wr_be   = 4'b0001 << req_addr[1:0];
            wr_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata[15:0]}};
         end
         default: begin
            wr_be   = 4'b1111;
            wr_data = req_wdata;
         end
      endcase
   end

   // One byte-wide RAM per lane so byte enables map onto plain inferred block RAM.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] rd_lane_reg;

         always_ff @(posedge CLK) begin
            if (ram_we && wr_be[gi])
               lane_mem[idx] <= wr_data[8*gi +: 8];
            if (ram_re)
               rd_lane_reg <= lane_mem[idx];
         end

         assign rd_word[8*gi +: 8] = rd_lane_reg;
      end
   endgenerate

   assign ld_word  = mmio_reg ? {29'b0, led_val} : rd_word;
   assign byte_sel = ld_word[8*lane_reg +: 8];
   assign half_sel = lane_reg[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_ext = ld_word;
      case (funct3_reg)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ld_ext = {24'b0, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  ld_ext = {16'b0, half_sel};
         default: ld_ext = ld_word;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= IDLE;
         ready_reg     <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= 32'b0;
         rsp_err_reg   <= 1'b0;
         funct3_reg    <= 3'b000;
         lane_reg      <= 2'b00;
         mmio_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               rsp_valid_reg <= 1'b0;
               if (accept) begin
                  funct3_reg <= req_funct3;
                  lane_reg   <= req_addr[1:0];
                  mmio_reg   <= is_mmio;
                  ready_reg  <= 1'b0;
                  if (!req_ok || req_we) begin
                     rsp_err_reg   <= !req_ok;
                     rsp_rdata_reg <= 32'b0;
                     rsp_valid_reg <= 1'b1;
                     state_reg     <= RESP;
                  end else begin
                     state_reg <= RD;
                  end
               end
            end
            RD: begin
               rsp_rdata_reg <= ld_ext;
               rsp_err_reg   <= 1'b0;
               rsp_valid_reg <= 1'b1;
               state_reg     <= RESP;
            end
            RESP: begin
               rsp_valid_reg <= 1'b0;
               ready_reg     <= 1'b1;
               state_reg     <= IDLE;
            end
            default: begin
               rsp_valid_reg <= 1'b0;
               ready_reg     <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign led_out   = led_val;

endmodule

// File: tb/tb_tiny_lsu.sv
// Scoreboard bench for tiny_lsu: driver pushes expected responses, a negedge monitor pops and checks.
// Covers both builds of TINY_LSU_MMIO_LED_EN.
module tb_tiny_lsu;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [2:0]  led_out;

   tiny_lsu #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .led_out(led_out)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL spurious_rsp: got rsp_valid=1 rdata=0x%08h expected no response", rsp_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("rsp %-14s rdata=0x%08h err=%0b lat=%0d", e.name, rsp_rdata, rsp_err, cyc - e.acc);
            chk({e.name, ".rdata"}, rsp_rdata, e.rdata);
            chk({e.name, ".err"}, {31'b0, rsp_err}, {31'b0, e.err});
            chk({e.name, ".lat"}, cyc - e.acc, e.lat);
         end
      end
   end

   task automatic issue(input string name, input bit we, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] wdata,
                        input bit push, input bit [31:0] erd, input bit eerr);
      int   waited = 0;
      bit   got = 0;
      exp_t e;
      while (!got && waited < 50) begin
         @(negedge CLK);
         if (req_ready === 1'b1) got = 1;
         else waited++;
      end
      if (!got) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s.ready_timeout: got req_ready=0 for 50 cycles expected 1", name);
         return;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      e.acc      = cyc;
      @(posedge CLK);
      #1;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom_range(0, 7));
      req_we     = 1'($urandom_range(0, 1));
      if (push) begin
         e.rdata = erd;
         e.err   = eerr;
         e.lat   = (we || eerr) ? 1 : 2;
         e.name  = name;
         exp_q.push_back(e);
      end
   endtask

   localparam bit [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst.rsp_rdata", rsp_rdata, 32'd0);
      chk("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst.led_out", {29'b0, led_out}, 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;

      issue("sw0_2a",   1, W,  32'h0, 32'h0000_002A, 1, 32'h0, 0);
      issue("lw0",      0, W,  32'h0, 32'h0,         1, 32'h0000_002A, 0);
      issue("sw4",      1, W,  32'h4, 32'h1122_3344, 1, 32'h0, 0);
      issue("sb5",      1, B,  32'h5, 32'h1234_5680, 1, 32'h0, 0);
      issue("lb5",      0, B,  32'h5, 32'h0,         1, 32'hFFFF_FF80, 0);
      issue("lbu5",     0, BU, 32'h5, 32'h0,         1, 32'h0000_0080, 0);
      issue("lw4",      0, W,  32'h4, 32'h0,         1, 32'h1122_8044, 0);
      issue("sh8",      1, H,  32'h8, 32'hABCD_8001, 1, 32'h0, 0);
      issue("lh8",      0, H,  32'h8, 32'h0,         1, 32'hFFFF_8001, 0);
      issue("lhu8",     0, HU, 32'h8, 32'h0,         1, 32'h0000_8001, 0);
      issue("lw2_mis",  0, W,  32'h2, 32'h0,         1, 32'h0, 1);
      issue("lw0_b",    0, W,  32'h0, 32'h0,         1, 32'h0000_002A, 0);
      issue("sbu_ill",  1, BU, 32'h0, 32'hFFFF_FFFF, 1, 32'h0, 1);
      issue("lw0_c",    0, W,  32'h0, 32'h0,         1, 32'h0000_002A, 0);
      issue("ld011",    0, 3'b011, 32'h0, 32'h0,     1, 32'h0, 1);
      issue("ld110",    0, 3'b110, 32'h0, 32'h0,     1, 32'h0, 1);
      issue("sh9_mis",  1, H,  32'h9, 32'h0000_1234, 1, 32'h0, 1);
      issue("shA",      1, H,  32'hA, 32'h5555_7FFF, 1, 32'h0, 0);
      issue("lw8",      0, W,  32'h8, 32'h0,         1, 32'h7FFF_8001, 0);
      issue("lhA",      0, H,  32'hA, 32'h0,         1, 32'h0000_7FFF, 0);
      issue("sb7",      1, B,  32'h7, 32'h0000_00A5, 1, 32'h0, 0);
      issue("lw4_b",    0, W,  32'h4, 32'h0,         1, 32'hA522_8044, 0);
      issue("lb7",      0, B,  32'h7, 32'h0,         1, 32'hFFFF_FFA5, 0);
      issue("sw400",    1, W,  32'h400, 32'hDEAD_BEEF, 1, 32'h0, 0);
      issue("lw0_wrap", 0, W,  32'h0, 32'h0,         1, 32'hDEAD_BEEF, 0);

      // Load accepted, then reset during its RD cycle: the response must vanish.
      issue("lw4_drop", 0, W,  32'h4, 32'h0,         0, 32'h0, 0);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rstrd.req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstrd.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      issue("lw4_post", 0, W,  32'h4, 32'h0,         1, 32'hA522_8044, 0);

`ifdef TINY_LSU_MMIO_LED_EN
      issue("sw_led5",  1, W,  32'h1000, 32'h0000_0005, 1, 32'h0, 0);
      @(negedge CLK);
      chk("led_after_sw", {29'b0, led_out}, 32'd5);
      issue("lw_led",   0, W,  32'h1000, 32'h0,    1, 32'h0000_0005, 0);
      issue("lb_led",   0, B,  32'h1000, 32'h0,    1, 32'h0000_0005, 0);
      issue("sb_led",   1, B,  32'h1000, 32'h0000_00FA, 1, 32'h0, 0);
      @(negedge CLK);
      chk("led_after_sb", {29'b0, led_out}, 32'd2);
      issue("lh_led",   0, H,  32'h1000, 32'h0,    1, 32'h0000_0002, 0);
      issue("lw0_noram",0, W,  32'h0, 32'h0,       1, 32'hDEAD_BEEF, 0);
      issue("lw_led_mis",0, W, 32'h1002, 32'h0,    1, 32'h0, 1);
`else
      issue("lw1000",   0, W,  32'h1000, 32'h0,    1, 32'hDEAD_BEEF, 0);
      issue("sw1000",   1, W,  32'h1000, 32'h0000_0005, 1, 32'h0, 0);
      @(negedge CLK);
      chk("led_const0", {29'b0, led_out}, 32'd0);
      issue("lw0_alias",0, W,  32'h0, 32'h0,       1, 32'h0000_0005, 0);
`endif

      begin
         int waited = 0;
         while (exp_q.size() != 0 && waited < 50) begin
            @(negedge CLK);
            waited++;
         end
         if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
         end
      end
      repeat (3) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
